// File: rtl/apple1_bus_ctrl.sv
// Apple-1 CPU bus controller: address decode, one-wait-state reads from ROM/RAM,
// and the keyboard/display PIA registers at $D010-$D013.
module apple1_bus_ctrl #(
  parameter int unsigned RAM_AW = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rdy,
  output logic [7:0]        rom_addr,
  input  logic [7:0]        rom_dout,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic [6:0]        kbd_data,
  input  logic              kbd_valid,
  output logic              kbd_ready,
  output logic [6:0]        dsp_data,
  output logic              dsp_valid,
  input  logic              dsp_ready
);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_ROM, SRC_RAM, SRC_PIA} src_t;

  state_t     state;
  src_t       sel;
  logic [7:0] pia_q;
  logic       kbd_flag;
  logic [6:0] kbd_reg;
  logic       dsp_busy;

  logic rom_hit, ram_hit, kbd_hit, kbdcr_hit, dsp_hit, dspcr_hit, pia_hit;
  logic req, wr;
  logic [7:0] pia_val;
  src_t       src_next;

  assign rom_hit   = (cpu_addr[15:8] == 8'hFF);
  assign ram_hit   = ((cpu_addr >> RAM_AW) == 16'd0);
  assign kbd_hit   = (cpu_addr == 16'hD010);
  assign kbdcr_hit = (cpu_addr == 16'hD011);
  assign dsp_hit   = (cpu_addr == 16'hD012);
  assign dspcr_hit = (cpu_addr == 16'hD013);
  assign pia_hit   = kbd_hit | kbdcr_hit | dsp_hit | dspcr_hit;

  // Only the IDLE cycle carries a live request; WAIT is the completion cycle.
  assign req = (state == IDLE) & cpu_re;
  assign wr  = (state == IDLE) & cpu_we;

  assign rom_addr  = cpu_addr[7:0];
  assign ram_addr  = cpu_addr[RAM_AW-1:0];
  assign ram_wdata = cpu_wdata;
  assign ram_we    = wr & ram_hit;
  assign cpu_rdy   = (state == WAIT) | ~cpu_re;
  assign kbd_ready = ~kbd_flag;
  assign dsp_valid = dsp_busy;

  always_comb begin
    pia_val  = 8'h00;
    src_next = SRC_NONE;
    if (kbd_hit)        pia_val = {1'b1, kbd_reg};
    else if (kbdcr_hit) pia_val = {kbd_flag, 7'b0};
    else if (dsp_hit)   pia_val = {dsp_busy, 7'b0};
    if (rom_hit)        src_next = SRC_ROM;
    else if (ram_hit)   src_next = SRC_RAM;
    else if (pia_hit)   src_next = SRC_PIA;
  end

  always_comb begin
    cpu_rdata = 8'h00;
    if (state == WAIT) begin
      case (sel)
        SRC_ROM: cpu_rdata = rom_dout;
        SRC_RAM: cpu_rdata = ram_rdata;
        SRC_PIA: cpu_rdata = pia_q;
        default: cpu_rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sel      <= SRC_NONE;
      pia_q    <= 8'h00;
      kbd_flag <= 1'b0;
      kbd_reg  <= 7'h00;
      dsp_busy <= 1'b0;
      dsp_data <= 7'h00;
    end else begin
      case (state)
        IDLE: if (cpu_re) begin
          sel   <= src_next;
          pia_q <= pia_val;
          state <= WAIT;
        end
        default: state <= IDLE;
      endcase

      // A key read clears the flag; an accept in the same cycle wins so no key is lost.
      if (req && kbd_hit) kbd_flag <= 1'b0;
      if (kbd_valid && !kbd_flag) begin
        kbd_reg  <= kbd_data;
        kbd_flag <= 1'b1;
      end

      // Consume has priority; a write while busy is dropped.
      if (dsp_busy && dsp_ready) begin
        dsp_busy <= 1'b0;
      end else if (wr && dsp_hit && !dsp_busy) begin
        dsp_data <= cpu_wdata[6:0];
        dsp_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apple1_bus_ctrl.sv
// Directed bench for apple1_bus_ctrl: ROM/RAM reads, PIA keyboard/display, reset abort.
module tb_apple1_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_re, cpu_we;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_rdy;
  logic [7:0]  rom_addr, rom_dout;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;
  logic [6:0]  kbd_data;
  logic        kbd_valid, kbd_ready;
  logic [6:0]  dsp_data;
  logic        dsp_valid, dsp_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apple1_bus_ctrl #(.RAM_AW(13)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
    .rom_addr(rom_addr), .rom_dout(rom_dout),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
    .dsp_data(dsp_data), .dsp_valid(dsp_valid), .dsp_ready(dsp_ready)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request cycle, then WAIT cycle with memory data driven as the synchronous memory would.
  task automatic do_read(input string tag, input logic [15:0] addr,
                         input logic [7:0] rom_d, input logic [7:0] ram_d,
                         input logic [7:0] exp);
    cpu_addr = addr; cpu_re = 1'b1;
    #1;
    chk({tag, "_stall"}, 16'(cpu_rdy), 16'h0);
    step();
    rom_dout = rom_d; ram_rdata = ram_d;
    #1;
    chk({tag, "_rdy"}, 16'(cpu_rdy), 16'h1);
    chk({tag, "_data"}, 16'(cpu_rdata), 16'(exp));
    step();
    cpu_re = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [15:0] addr, input logic [7:0] d);
    cpu_addr = addr; cpu_we = 1'b1; cpu_wdata = d;
    #1;
    chk({tag, "_rdy"}, 16'(cpu_rdy), 16'h1);
    step();
    cpu_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_addr = 16'h0000; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wdata = 8'h00;
    rom_dout = 8'h00; ram_rdata = 8'h00; kbd_data = 7'h00; kbd_valid = 1'b0; dsp_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_rdy", 16'(cpu_rdy), 16'h1);
    chk("rst_rdata", 16'(cpu_rdata), 16'h00);
    chk("rst_kbd_ready", 16'(kbd_ready), 16'h1);
    chk("rst_dsp_valid", 16'(dsp_valid), 16'h0);
    chk("rst_dsp_data", 16'(dsp_data), 16'h00);
    chk("rst_ram_we", 16'(ram_we), 16'h0);
    step();

    // Reset vector fetch, back to back.
    cpu_addr = 16'hFFFC; #1;
    chk("rom_addr_fc", 16'(rom_addr), 16'h00FC);
    do_read("rom_fffc", 16'hFFFC, 8'h00, 8'hEE, 8'h00);
    cpu_addr = 16'hFFFD; #1;
    chk("rom_addr_fd", 16'(rom_addr), 16'h00FD);
    do_read("rom_fffd", 16'hFFFD, 8'hFF, 8'hEE, 8'hFF);

    // Keyboard handshake.
    kbd_data = 7'h41; kbd_valid = 1'b1;
    #1;
    chk("kbd_ready_pre", 16'(kbd_ready), 16'h1);
    step();
    kbd_valid = 1'b0;
    chk("kbd_ready_fall", 16'(kbd_ready), 16'h0);
    do_read("kbdcr_set", 16'hD011, 8'hEE, 8'hEE, 8'h80);
    do_read("kbd_read", 16'hD010, 8'hEE, 8'hEE, 8'hC1);
    do_read("kbdcr_clr", 16'hD011, 8'hEE, 8'hEE, 8'h00);
    chk("kbd_ready_back", 16'(kbd_ready), 16'h1);

    // Display handshake.
    do_write("dsp_wr1", 16'hD012, 8'h8D);
    chk("dsp_valid_set", 16'(dsp_valid), 16'h1);
    chk("dsp_data_0d", 16'(dsp_data), 16'h0D);
    do_read("dsp_busy_rd", 16'hD012, 8'hEE, 8'hEE, 8'h80);
    do_write("dsp_wr_drop", 16'hD012, 8'hC1);
    chk("dsp_data_kept", 16'(dsp_data), 16'h0D);
    dsp_ready = 1'b1;
    step();
    dsp_ready = 1'b0;
    chk("dsp_valid_clr", 16'(dsp_valid), 16'h0);
    chk("dsp_data_hold", 16'(dsp_data), 16'h0D);
    do_read("dsp_idle_rd", 16'hD012, 8'hEE, 8'hEE, 8'h00);
    do_read("dspcr_rd", 16'hD013, 8'hEE, 8'hEE, 8'h00);

    // RAM write and read.
    cpu_addr = 16'h0200; cpu_we = 1'b1; cpu_wdata = 8'h5A;
    #1;
    chk("ram_we_on", 16'(ram_we), 16'h1);
    chk("ram_addr", 16'(ram_addr), 16'h0200);
    chk("ram_wdata", 16'(ram_wdata), 16'h005A);
    chk("ram_wr_rdy", 16'(cpu_rdy), 16'h1);
    step();
    cpu_we = 1'b0;
    #1;
    chk("ram_we_off", 16'(ram_we), 16'h0);
    do_read("ram_rd", 16'h0200, 8'hEE, 8'h5A, 8'h5A);

    // Unmapped read returns zero even with junk on the memory buses.
    do_read("unmapped", 16'hC000, 8'hFF, 8'hFF, 8'h00);
    cpu_addr = 16'hC000; cpu_we = 1'b1; #1;
    chk("unmapped_no_we", 16'(ram_we), 16'h0);
    step();
    cpu_we = 1'b0;

    // Control-register writes leave the keyboard flag alone.
    kbd_data = 7'h42; kbd_valid = 1'b1;
    step();
    kbd_valid = 1'b0;
    do_write("kbdcr_wr", 16'hD011, 8'hA7);
    do_write("dspcr_wr", 16'hD013, 8'hA7);
    chk("kbd_flag_kept", 16'(kbd_ready), 16'h0);
    do_read("kbdcr_kept", 16'hD011, 8'hEE, 8'hEE, 8'h80);

    // Reset in the middle of a read with a pending key and display character.
    do_write("dsp_wr2", 16'hD012, 8'hC1);
    chk("dsp_busy_pre_rst", 16'(dsp_valid), 16'h1);
    cpu_addr = 16'hD010; cpu_re = 1'b1;
    step();
    chk("wait_before_rst", 16'(cpu_rdata), 16'h00C2);
    reset = 1'b1; cpu_re = 1'b0;
    #1;
    chk("abort_rdy", 16'(cpu_rdy), 16'h1);
    chk("abort_rdata", 16'(cpu_rdata), 16'h00);
    chk("abort_dsp_valid", 16'(dsp_valid), 16'h0);
    chk("abort_kbd_ready", 16'(kbd_ready), 16'h1);
    step();
    reset = 1'b0;
    step();
    do_read("post_rst_kbdcr", 16'hD011, 8'hEE, 8'hEE, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apple1_bus_ctrl.md
Name: apple1_bus_ctrl

Overview:
- CPU-side bus controller for the Apple-1 system. It sits between the 6502 core and the monitor ROM, the main RAM and the keyboard/display I/O.
- Decodes CPU addresses and drives the 8-bit ROM address. Inserts one wait state so that synchronous ROM/RAM read data can be returned.
- Implements the PIA-compatible keyboard/display registers at $D010-$D013 that the monitor firmware polls, including valid/ready handshakes toward the host-side terminal.

Parameters:
- RAM_AW, 13, RAM address width; RAM occupies $0000..(2^RAM_AW - 1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  16  CPU address, held stable while cpu_rdy=0
- cpu_re  in  1  CPU read request for this cycle
- cpu_we  in  1  CPU write request for this cycle; cpu_re and cpu_we are never both 1
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data to CPU
- cpu_rdy  out  1  0 = stall CPU
- rom_addr  out  8  to ROM, = cpu_addr[7:0]
- rom_dout  in  8  ROM data, valid 1 cycle after rom_addr
- ram_addr  out  RAM_AW  = cpu_addr[RAM_AW-1:0]
- ram_we  out  1  RAM write strobe
- ram_wdata  out  8  = cpu_wdata
- ram_rdata  in  8  RAM data, valid 1 cycle after ram_addr
- kbd_data  in  7  ASCII from terminal
- kbd_valid  in  1  keyboard character offered
- kbd_ready  out  1  controller accepts character
- dsp_data  out  7  character to terminal
- dsp_valid  out  1  display character pending
- dsp_ready  in  1  terminal consumes character

Behaviour:
- Address decode:
  - ROM = $FF00-$FFFF.
  - RAM = addr < 2^RAM_AW.
  - KBD = $D010, KBDCR = $D011, DSP = $D012, DSPCR = $D013.
  - Everything else is unmapped: reads return $00, writes are ignored.
- rom_addr, ram_addr and ram_wdata are combinational from the CPU bus.
- ram_we = cpu_we & RAM hit (combinational, single cycle).
- FSM states IDLE and WAIT:
  - In IDLE, cpu_rdy = ~cpu_re (combinational). On cpu_re, latch the source select and PIA snapshot, then go to WAIT.
  - In WAIT, cpu_rdy=1 and cpu_rdata = selected source (rom_dout, ram_rdata, or latched PIA value). Return to IDLE unconditionally.
  - Read latency is 2 cycles with one stall cycle; back-to-back reads are allowed.
  - Writes complete in 1 cycle with no stall. A write presented in WAIT is ignored; the CPU is stalled in IDLE only.
- Keyboard:
  - kbd_ready = ~kbd_flag.
  - When kbd_valid & kbd_ready: kbd_reg <= kbd_data, kbd_flag <= 1.
  - KBD read returns {1, kbd_reg} and clears kbd_flag at the end of the request cycle.
  - KBDCR read returns {kbd_flag, 7'b0}.
  - A new character cannot arrive in the same cycle as the clearing read because ready is 0; it is accepted at the earliest the cycle after.
- Display:
  - dsp_valid = dsp_busy.
  - A DSP write with dsp_busy=0 latches cpu_wdata[6:0] into dsp_data and sets dsp_busy. A DSP write while busy is dropped.
  - dsp_valid & dsp_ready clears dsp_busy. dsp_data holds its value after the clear.
  - DSP read returns {dsp_busy, 7'b0}. DSPCR read returns $00.
  - Simultaneous write and consume: the consume clears busy; the write is dropped because busy was 1 at the edge.
- Writes to KBD, KBDCR and DSPCR are accepted and ignored (the firmware writes $A7 to the control registers).
- PIA read values are snapshotted in the request cycle.
- Reset values:
  - state = IDLE, cpu_rdy = 1 (when cpu_re=0), cpu_rdata = $00.
  - kbd_flag = 0, kbd_reg = 0, kbd_ready = 1.
  - dsp_busy = 0, dsp_valid = 0, dsp_data = 0, ram_we = 0 (when cpu_we=0).
- Reset asserted mid-WAIT aborts the read. A pending display character and an unread key are discarded.

Test Plan:
- Reset, then read $FFFC with rom_dout=$00 on the next cycle, then $FFFD with $FF → rom_addr=$FC/$FD, cpu_rdy low exactly 1 cycle each, cpu_rdata $00 then $FF.
- kbd_valid=1, kbd_data=$41 → kbd_ready falls next cycle. Read $D011 → $80. Read $D010 → $C1. Read $D011 → $00. kbd_ready=1 again.
- dsp_ready=0, write $D012=$8D → dsp_valid=1, dsp_data=$0D. Read $D012 → $80. Write $D012=$C1 → dropped, dsp_data stays $0D. Pulse dsp_ready 1 cycle → dsp_valid=0. Read $D012 → $00.
- Write $0200=$5A → ram_we pulses 1 cycle, ram_addr=$0200, cpu_rdy stays 1. Read $0200 with ram_rdata=$5A → cpu_rdata=$5A after 1 stall.
- Read $C000 → $00. Write $D011=$A7 → no state change, kbd_flag unchanged.
- Assert reset during WAIT with dsp_busy=1 and kbd_flag=1 → immediately state IDLE, dsp_valid=0, kbd_ready=1, cpu_rdata=$00.
